multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle sequencer for the 16-bit processor datapath. It steps each instruction through fetch, decode, execute, memory and write-back, and issues every datapath select and enable for each step. Memory accesses use a req/ack handshake, so wait states are absorbed without corrupting state. The block sits between the instruction register's opcode field and the shared datapath: register file, ALU, PC, and unified instruction/data memory.

## Interface
- `ACK_TIMEOUT`, default 255: consecutive cycles `mem_req` may wait for `mem_ack` before entering ILLEGAL. 0 disables the timeout.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 4: `IR[15:12]`, valid from DECODE onward.
- `zero` input 1: ALU zero flag, sampled in BRANCH.
- `mem_ack` input 1: memory completed the requested access this cycle.
- `mem_req` output 1: memory access request.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` output 1 each: access type, valid while `mem_req` is high.
- `ir_write` output 1: load the instruction register.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load when `zero` is 1.
- `pc_source` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = B, 01 = constant 1, 10 = sign-extended immediate.
- `alu_op` output 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `mem_to_reg` output 1: 0 = ALUOut, 1 = MDR.
- `reg_write` output 1: register file write enable.
- `halted`, `illegal` output 1 each: sticky status flags.
- `instr_count` output 16: count of retired instructions.

## Operation
Opcodes:
- 0000 R-type
- 0001 LW
- 0010 SW
- 0011 BEQ
- 0100 ADDI
- 0101 J
- 1111 HALT
- All other opcodes are illegal.

States and transitions:
- FETCH: `mem_req`=1, `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00. On the cycle `mem_ack`=1, also `ir_write`=1, `pc_write`=1, `pc_source`=00, then go to DECODE. Otherwise hold.
- DECODE: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=00 to compute the branch target. Next state by opcode:
  - R-type → EXEC_R
  - LW, SW → MEM_ADDR
  - BEQ → BRANCH
  - ADDI → EXEC_I
  - J → JUMP
  - HALT → HALT
  - otherwise → ILLEGAL
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → WB_R.
- WB_R: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1 → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → MEM_RD if LW, MEM_WR if SW.
- MEM_RD: `mem_req`=1, `mem_read`=1, `iord`=1; hold until `mem_ack` → WB_MEM.
- WB_MEM: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1 → FETCH.
- MEM_WR: `mem_req`=1, `mem_write`=1, `iord`=1; hold until `mem_ack` → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01 → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → WB_I.
- WB_I: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1 → FETCH.
- JUMP: `pc_write`=1, `pc_source`=10 → FETCH.
- HALT, ILLEGAL: terminal. All enables are 0; `halted` or `illegal` is 1. Only `reset` exits.

Retirement and signal rules:
- `instr_count` increments by 1 on the last cycle of each instruction: WB_R, WB_MEM, the acked MEM_WR cycle, BRANCH, WB_I, JUMP, and the first HALT cycle.
- `instr_count` wraps from 0xFFFF to 0x0000.
- Every output not listed for a state is 0.
- `mem_read` and `mem_write` are never both 1.
- `reg_write` and `mem_write` are never both 1.

## Timing
- Outputs are combinational from the registered state plus `mem_ack`. `ir_write` and the FETCH `pc_write` are qualified by `mem_ack`.
- While `reset` is high, all outputs are 0 regardless of state.
- On the clock edge with `reset`=1: state becomes FETCH, `instr_count`=0, wait counter=0, `halted`=0, `illegal`=0. First fetch request appears in the cycle after `reset` falls.
- Latency with zero memory wait, FETCH acked in its first cycle:
  - R-type, ADDI, SW: 4 cycles
  - LW: 5 cycles
  - BEQ, J: 3 cycles
- Each wait cycle adds 1 cycle.
- Handshake:
  - `mem_req` and access type stay stable until the ack cycle. `mem_req` deasserts in the following cycle unless the next state is another access state.
  - `mem_ack` with `mem_req`=0 is ignored.
- Wait counter: cleared on entry to FETCH, MEM_RD or MEM_WR, and on ack; otherwise increments while `mem_req` is high. Reaching `ACK_TIMEOUT` (if nonzero) → ILLEGAL next cycle.
- `reset` mid-instruction aborts it; the partial instruction is not counted.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state enum (4-bit encoding)
  - opcode constants
  - `alu_op`, `alu_src_b` and `pc_source` encodings
- Sub-module `control_output_decode` is purely combinational: state + `mem_ack` → output bundle.
- Top level holds the state register, wait counter, `instr_count` and sticky flags.

## Test plan
- Reset, then R-type (0000) with `mem_ack` tied high → `reg_write`=1 with `reg_dst`=1 in the 4th cycle after reset release; `instr_count`=1.
- LW (0001), `mem_ack` delayed 2 cycles in both FETCH and MEM_RD → 9 cycles total; `iord`=1 only in MEM_RD; `mem_to_reg`=1 in WB_MEM.
- BEQ (0011) with `zero`=1, then again with `zero`=0 → `pc_write_cond`=1, `pc_source`=01, `alu_op`=01 in BRANCH in both cases; 3 cycles each.
- Opcode 1010 → ILLEGAL after DECODE; `illegal`=1; all enables 0 for 20 cycles; `reset` clears the flag.
- `ACK_TIMEOUT`=4, `mem_ack` held low in FETCH → `illegal`=1 after 4 request cycles.
- Set `instr_count` to 0xFFFF, then retire J (0101) → wraps to 0x0000. HALT (1111) → `halted`=1, `mem_req` stays 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared types and encodings for the multi-cycle control unit:
//            state enumeration, opcode values, datapath select encodings
//            and the control output bundle.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

   // Controller states, 4-bit encoding
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_WB_R     = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_MEM_RD   = 4'd5,
      ST_WB_MEM   = 4'd6,
      ST_MEM_WR   = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_EXEC_I   = 4'd9,
      ST_WB_I     = 4'd10,
      ST_JUMP     = 4'd11,
      ST_HALT     = 4'd12,
      ST_ILLEGAL  = 4'd13
   } state_e;

   // Opcodes (IR[15:12])
   localparam logic [3:0] c_op_rtype = 4'b0000;
   localparam logic [3:0] c_op_lw    = 4'b0001;
   localparam logic [3:0] c_op_sw    = 4'b0010;
   localparam logic [3:0] c_op_beq   = 4'b0011;
   localparam logic [3:0] c_op_addi  = 4'b0100;
   localparam logic [3:0] c_op_j     = 4'b0101;
   localparam logic [3:0] c_op_halt  = 4'b1111;

   // ALU operation select
   localparam logic [1:0] c_alu_add   = 2'b00;
   localparam logic [1:0] c_alu_sub   = 2'b01;
   localparam logic [1:0] c_alu_funct = 2'b10;

   // ALU operand B select
   localparam logic [1:0] c_srcb_reg = 2'b00;
   localparam logic [1:0] c_srcb_one = 2'b01;
   localparam logic [1:0] c_srcb_imm = 2'b10;

   // PC source select
   localparam logic [1:0] c_pcsrc_alu    = 2'b00;
   localparam logic [1:0] c_pcsrc_aluout = 2'b01;
   localparam logic [1:0] c_pcsrc_jump   = 2'b10;

   // Per-state control bundle; retire marks the final cycle of an instruction
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       retire;
   } ctrl_out_t;

endpackage
`default_nettype wire

// File: rtl/control_output_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_output_decode
// Purpose  : Purely combinational decode of controller state (plus mem_ack)
//            into the datapath control bundle.
// Ports    : state   - current controller state
//            mem_ack - memory handshake acknowledge
//            ctrl    - control bundle for this cycle
// Revision : 1.0 - initial release
// ============================================================================
module control_output_decode
   import cpu_ctrl_pkg::*;
(
   input  state_e    state,
   input  logic      mem_ack,
   output ctrl_out_t ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = c_srcb_one;
            ctrl.alu_op    = c_alu_add;
            // IR and PC+1 are only committed once the fetch data is there
            if (mem_ack) begin
               ctrl.ir_write  = 1'b1;
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = c_pcsrc_alu;
            end
         end
         ST_DECODE: begin
            ctrl.alu_src_b = c_srcb_imm;
            ctrl.alu_op    = c_alu_add;
         end
         ST_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_reg;
            ctrl.alu_op    = c_alu_funct;
         end
         ST_WB_R: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.retire    = 1'b1;
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_imm;
            ctrl.alu_op    = c_alu_add;
         end
         ST_MEM_RD: begin
            ctrl.mem_req  = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         ST_WB_MEM: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.retire     = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.retire    = mem_ack;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = c_srcb_reg;
            ctrl.alu_op        = c_alu_sub;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = c_pcsrc_aluout;
            ctrl.retire        = 1'b1;
         end
         ST_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_imm;
            ctrl.alu_op    = c_alu_add;
         end
         ST_WB_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.retire    = 1'b1;
         end
         ST_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = c_pcsrc_jump;
            ctrl.retire    = 1'b1;
         end
         // HALT, ILLEGAL and unused encodings drive nothing
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle sequencer for the 16-bit datapath. Steps each
//            instruction through fetch/decode/execute/memory/write-back and
//            drives all datapath selects and enables. Memory accesses use a
//            req/ack handshake with an optional timeout into ILLEGAL.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            opcode, zero      - IR[15:12], ALU zero flag
//            mem_ack           - memory access complete this cycle
//            mem_req..reg_write- datapath control outputs
//            halted, illegal   - sticky status flags
//            instr_count       - retired instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_source,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] instr_count
);

   localparam int c_wait_w = 16;

   state_e              state_q, state_d;
   logic [c_wait_w-1:0] wait_q, wait_d;
   logic [15:0]         instr_count_q, instr_count_d;
   logic                halted_q, halted_d;
   logic                illegal_q, illegal_d;
   logic                halt_retired_q, halt_retired_d;

   ctrl_out_t           w_ctrl;
   logic                w_retire;
   logic                w_unused_zero;

   // The branch decision is taken in the datapath (pc_write_cond & zero),
   // so the sequencer itself never needs the flag.
   assign w_unused_zero = zero;

   control_output_decode u_decode (
      .state   (state_q),
      .mem_ack (mem_ack),
      .ctrl    (w_ctrl)
   );

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      instr_count_d  = instr_count_q;
      halt_retired_d = halt_retired_q;

      case (state_q)
         ST_FETCH:    if (mem_ack) state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               c_op_rtype:      state_d = ST_EXEC_R;
               c_op_lw,
               c_op_sw:         state_d = ST_MEM_ADDR;
               c_op_beq:        state_d = ST_BRANCH;
               c_op_addi:       state_d = ST_EXEC_I;
               c_op_j:          state_d = ST_JUMP;
               c_op_halt:       state_d = ST_HALT;
               default:         state_d = ST_ILLEGAL;
            endcase
         end
         ST_EXEC_R:   state_d = ST_WB_R;
         ST_WB_R:     state_d = ST_FETCH;
         ST_MEM_ADDR: state_d = (opcode == c_op_sw) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:   if (mem_ack) state_d = ST_WB_MEM;
         ST_WB_MEM:   state_d = ST_FETCH;
         ST_MEM_WR:   if (mem_ack) state_d = ST_FETCH;
         ST_BRANCH:   state_d = ST_FETCH;
         ST_EXEC_I:   state_d = ST_WB_I;
         ST_WB_I:     state_d = ST_FETCH;
         ST_JUMP:     state_d = ST_FETCH;
         ST_HALT:     state_d = ST_HALT;
         ST_ILLEGAL:  state_d = ST_ILLEGAL;
         default:     state_d = ST_ILLEGAL;
      endcase

      // Wait counter: counts unacknowledged request cycles. Non-request
      // states always clear it, so each access state is entered with zero.
      if (w_ctrl.mem_req && !mem_ack) begin
         if (wait_q != {c_wait_w{1'b1}}) begin
            wait_d = wait_q + 1'b1;
         end
         // The cycle in which the count reaches the limit is the last one
         if ((ACK_TIMEOUT != 32'd0) && ((32'(wait_q) + 32'd1) >= ACK_TIMEOUT)) begin
            state_d = ST_ILLEGAL;
         end
      end else begin
         wait_d = '0;
      end

      // HALT retires only in its first cycle
      w_retire = w_ctrl.retire || ((state_q == ST_HALT) && !halt_retired_q);
      if (state_q == ST_HALT) begin
         halt_retired_d = 1'b1;
      end
      if (w_retire) begin
         instr_count_d = instr_count_q + 16'd1;
      end

      halted_d  = halted_q  || (state_d == ST_HALT);
      illegal_d = illegal_q || (state_d == ST_ILLEGAL);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_FETCH;
         wait_q         <= '0;
         instr_count_q  <= '0;
         halted_q       <= 1'b0;
         illegal_q      <= 1'b0;
         halt_retired_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         instr_count_q  <= instr_count_d;
         halted_q       <= halted_d;
         illegal_q      <= illegal_d;
         halt_retired_q <= halt_retired_d;
      end
   end

   // All outputs are forced low while reset is asserted
   always_comb begin
      mem_req       = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      halted        = 1'b0;
      illegal       = 1'b0;
      instr_count   = 16'd0;
      if (!reset) begin
         mem_req       = w_ctrl.mem_req;
         iord          = w_ctrl.iord;
         mem_read      = w_ctrl.mem_read;
         mem_write     = w_ctrl.mem_write;
         ir_write      = w_ctrl.ir_write;
         pc_write      = w_ctrl.pc_write;
         pc_write_cond = w_ctrl.pc_write_cond;
         pc_source     = w_ctrl.pc_source;
         alu_src_a     = w_ctrl.alu_src_a;
         alu_src_b     = w_ctrl.alu_src_b;
         alu_op        = w_ctrl.alu_op;
         reg_dst       = w_ctrl.reg_dst;
         mem_to_reg    = w_ctrl.mem_to_reg;
         reg_write     = w_ctrl.reg_write;
         halted        = halted_q;
         illegal       = illegal_q;
         instr_count   = instr_count_q;
      end
   end

endmodule
`default_nettype wire
